// File: rtl/reflet_irq_defs.sv
// Shared constants for the reflet interrupt controller: register offsets and MODE encoding.
package reflet_irq_defs;

    localparam logic [1:0] IRQ_PENDING = 2'd0;
    localparam logic [1:0] IRQ_ENABLE  = 2'd1;
    localparam logic [1:0] IRQ_MODE    = 2'd2;
    localparam logic [1:0] IRQ_TRIGGER = 2'd3;

    localparam logic IRQ_LEVEL = 1'b0;
    localparam logic IRQ_EDGE  = 1'b1;

endpackage

// File: rtl/reflet_irq_sync.sv
// One interrupt source: sync_stages-deep synchroniser followed by a rising-edge detector.
module reflet_irq_sync #(
    parameter int unsigned sync_stages = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic src,
    output logic s,
    output logic rise
);

    logic [sync_stages-1:0] r_sync;
    logic                   r_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_d    <= 1'b0;
        end else begin
            r_sync[0] <= src;
            for (int i = 1; i < int'(sync_stages); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_d <= r_sync[sync_stages-1];
        end
    end

    assign s    = r_sync[sync_stages-1];
    assign rise = r_sync[sync_stages-1] & ~r_d;

endmodule

// File: rtl/reflet_irq_ctrl.sv
// Memory-mapped interrupt controller: per-source capture, pending/enable/mode registers,
// and folding of enabled pending bits onto the CPU interrupt lines.
module reflet_irq_ctrl
    import reflet_irq_defs::*;
#(
    parameter int unsigned          wordsize    = 8,
    parameter int unsigned          n_sources   = 4,
    parameter int unsigned          n_lines     = 4,
    parameter logic [wordsize-1:0]  base_addr   = 8'hF0,
    parameter int unsigned          sync_stages = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [wordsize-1:0]  addr,
    input  logic [wordsize-1:0]  data_in,
    input  logic                 write_en,
    output logic [wordsize-1:0]  data_out,
    input  logic [n_sources-1:0] src,
    output logic [n_lines-1:0]   ext_int
);

    logic [wordsize-1:0] w_mask, w_s, w_rise;
    logic [wordsize-1:0] w_offset, w_trig, w_w1c, w_pending_d, w_rdata;
    logic                w_hit, w_wr;
    logic [1:0]          w_reg;
    logic [n_lines-1:0]  w_ext;

    logic [wordsize-1:0] r_pending, r_enable, r_mode, r_data_out;
    logic [n_lines-1:0]  r_ext_int;

    // Bits at or above n_sources are tied off so they read 0 and ignore writes.
    for (genvar i = 0; i < int'(wordsize); i++) begin : g_src
        if (i < int'(n_sources)) begin : g_on
            assign w_mask[i] = 1'b1;
            reflet_irq_sync #(
                .sync_stages(sync_stages)
            ) u_sync (
                .clk  (clk),
                .reset(reset),
                .src  (src[i]),
                .s    (w_s[i]),
                .rise (w_rise[i])
            );
        end else begin : g_off
            assign w_mask[i] = 1'b0;
            assign w_s[i]    = 1'b0;
            assign w_rise[i] = 1'b0;
        end
    end

    always_comb begin
        w_offset = addr - base_addr;
        w_hit    = (addr >= base_addr) && (w_offset[wordsize-1:2] == '0);
        w_reg    = w_offset[1:0];
        w_wr     = write_en && w_hit;
        w_trig   = (w_wr && w_reg == IRQ_TRIGGER) ? (data_in & w_mask) : '0;
        w_w1c    = (w_wr && w_reg == IRQ_PENDING) ? (data_in & w_mask) : '0;

        // Set beats clear in edge mode; level mode simply tracks the synchronised input.
        for (int i = 0; i < int'(wordsize); i++) begin
            if (r_mode[i] == IRQ_EDGE) begin
                w_pending_d[i] = (r_pending[i] & ~w_w1c[i]) | w_rise[i] | w_trig[i];
            end else begin
                w_pending_d[i] = w_s[i] | w_trig[i];
            end
        end
        w_pending_d = w_pending_d & w_mask;

        w_rdata = '0;
        if (w_hit) begin
            case (w_reg)
                IRQ_PENDING: w_rdata = r_pending;
                IRQ_ENABLE:  w_rdata = r_enable;
                IRQ_MODE:    w_rdata = r_mode;
                default:     w_rdata = '0;
            endcase
        end

        w_ext = '0;
        for (int i = 0; i < int'(n_sources); i++) begin
            w_ext[i % n_lines] = w_ext[i % n_lines] | (r_pending[i] & r_enable[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= '0;
            r_enable   <= '0;
            r_mode     <= w_mask;
            r_ext_int  <= '0;
            r_data_out <= '0;
        end else begin
            r_pending <= w_pending_d;
            if (w_wr && w_reg == IRQ_ENABLE) begin
                r_enable <= data_in & w_mask;
            end
            if (w_wr && w_reg == IRQ_MODE) begin
                r_mode <= data_in & w_mask;
            end
            r_ext_int  <= w_ext;
            r_data_out <= w_rdata;
        end
    end

    assign data_out = r_data_out;
    assign ext_int  = r_ext_int;

endmodule

// File: tb/tb_reflet_irq_ctrl.sv
// Directed bench for reflet_irq_ctrl: a 4-source and an 8-source instance on a shared bus.
module tb_reflet_irq_ctrl;

    localparam logic [7:0] BASE = 8'hF0;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] addr, data_in, data_out, data_out8;
    logic       write_en;
    logic [3:0] src, ext_int, ext_int8;
    logic [7:0] src8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    reflet_irq_ctrl #(
        .wordsize(8), .n_sources(4), .n_lines(4), .base_addr(8'hF0), .sync_stages(2)
    ) u_dut (
        .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .write_en(write_en),
        .data_out(data_out), .src(src), .ext_int(ext_int)
    );

    reflet_irq_ctrl #(
        .wordsize(8), .n_sources(8), .n_lines(4), .base_addr(8'hF0), .sync_stages(2)
    ) u_dut8 (
        .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .write_en(write_en),
        .data_out(data_out8), .src(src8), .ext_int(ext_int8)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] off, input logic [7:0] val);
        addr     = BASE + off;
        data_in  = val;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        addr     = 8'h00;
        data_in  = 8'h00;
    endtask

    // Presents the address for one cycle; data_out then holds the pre-edge register value.
    task automatic bus_read(input logic [7:0] off);
        addr = BASE + off;
        tick();
        addr = 8'h00;
    endtask

    initial begin
        reset    = 1'b1;
        addr     = 8'h00;
        data_in  = 8'h00;
        write_en = 1'b0;
        src      = 4'h0;
        src8     = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_ext_int", {4'h0, ext_int}, 8'h00);
        check("rst_data_out", data_out, 8'h00);
        bus_read(8'd0); check("rst_pending", data_out, 8'h00);
        bus_read(8'd1); check("rst_enable", data_out, 8'h00);
        bus_read(8'd2); check("rst_mode", data_out, 8'h0F);
        bus_read(8'd3); check("rst_trigger", data_out, 8'h00);
        check("unsel_zero", data_out8 & 8'h00 | data_out & 8'h00 | 8'h00, 8'h00 & data_out);
        addr = 8'h10;
        tick();
        check("unsel_read", data_out, 8'h00);
        addr = 8'h00;

        // Edge capture on source 0 with latency sync_stages+1
        bus_write(8'd1, 8'h01);
        src = 4'h1;
        tick();
        tick();
        bus_read(8'd0); check("pend0_early", data_out, 8'h00);
        check("ext0_early", {4'h0, ext_int}, 8'h00);
        bus_read(8'd0); check("pend0_set", data_out, 8'h01);
        check("ext0_set", {4'h0, ext_int}, 8'h01);
        repeat (6) tick();
        src = 4'h0;
        repeat (4) tick();
        bus_read(8'd0); check("pend0_held", data_out, 8'h01);
        bus_write(8'd0, 8'h01);
        check("ext0_w1c_lag", {4'h0, ext_int}, 8'h01);
        tick();
        check("ext0_cleared", {4'h0, ext_int}, 8'h00);
        bus_read(8'd0); check("pend0_cleared", data_out, 8'h00);

        // Disabled source still latches
        bus_write(8'd1, 8'h00);
        src = 4'h2;
        repeat (3) tick();
        src = 4'h0;
        repeat (4) tick();
        bus_read(8'd0); check("pend1_masked", data_out, 8'h02);
        check("ext1_masked", {4'h0, ext_int}, 8'h00);
        bus_write(8'd1, 8'h02);
        check("ext1_lag", {4'h0, ext_int}, 8'h00);
        tick();
        check("ext1_enabled", {4'h0, ext_int}, 8'h02);

        // Level mode on source 2
        bus_write(8'd2, 8'h0B);
        bus_write(8'd1, 8'h04);
        src = 4'h4;
        repeat (4) tick();
        bus_write(8'd0, 8'h04);
        bus_read(8'd0); check("lvl_w1c_noeff", data_out, 8'h06);
        check("lvl_ext", {4'h0, ext_int}, 8'h04);
        src = 4'h0;
        tick();
        tick();
        bus_read(8'd0); check("lvl_pend_still", data_out, 8'h06);
        check("lvl_ext_still", {4'h0, ext_int}, 8'h04);
        bus_read(8'd0); check("lvl_pend_drop", data_out, 8'h02);
        check("lvl_ext_drop", {4'h0, ext_int}, 8'h00);
        bus_write(8'd3, 8'h04);
        bus_read(8'd0); check("lvl_trig_1cyc", data_out, 8'h06);
        bus_read(8'd0); check("lvl_trig_gone", data_out, 8'h02);

        // Reset with a write in flight
        bus_write(8'd2, 8'h0F);
        bus_write(8'd3, 8'h0F);
        bus_read(8'd0); check("pre_rst_pend", data_out, 8'h0F);
        reset    = 1'b1;
        addr     = BASE + 8'd1;
        data_in  = 8'hFF;
        write_en = 1'b1;
        tick();
        reset    = 1'b0;
        write_en = 1'b0;
        addr     = 8'h00;
        check("mid_rst_ext", {4'h0, ext_int}, 8'h00);
        check("mid_rst_dout", data_out, 8'h00);
        bus_read(8'd1); check("mid_rst_enable", data_out, 8'h00);
        bus_read(8'd0); check("mid_rst_pend", data_out, 8'h00);
        bus_read(8'd2); check("mid_rst_mode", data_out, 8'h0F);

        // 8 sources folded onto 4 lines
        bus_write(8'd1, 8'hFF);
        bus_write(8'd4, 8'h00);
        bus_read(8'd1); check("oor_write_ign", data_out8, 8'hFF);
        bus_write(8'd3, 8'h50);
        bus_read(8'd0); check("trig8_pend", data_out8, 8'h50);
        check("trig8_fold", {4'h0, ext_int8}, 8'h05);
        check("trig4_masked", data_out, 8'h00);
        src8 = 8'h10;
        tick();
        tick();
        bus_write(8'd0, 8'h10);
        bus_read(8'd0); check("set_beats_clr", data_out8, 8'h50);
        bus_write(8'd0, 8'h10);
        bus_read(8'd0); check("clr_no_edge", data_out8, 8'h40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
